// File: rtl/bira_ctrl_if.sv
// bira_ctrl_if: BIST, analyzer and solution-stream signals of the BIRA controller.
interface bira_ctrl_if #(
    parameter int NUM_CAND  = 64,
    parameter int NUM_SPARE = 8
);
    logic [1:0]                   spare_struct;
    logic                         test_end;
    logic                         fault_detect;
    logic                         pivot_new;
    logic                         eval_pass;
    logic [NUM_SPARE-1:0]         spare_used;
    logic [15:0]                  sol_in;
    logic                         sol_ready;
    logic [$clog2(NUM_CAND)-1:0]  cand_idx;
    logic [$clog2(NUM_SPARE)-1:0] sol_sel;
    logic [15:0]                  solution;
    logic                         sol_valid;
    logic                         early_term;
    logic                         repair;
    logic                         done;
    logic                         busy;

    modport master (
        input  spare_struct, test_end, fault_detect, pivot_new, eval_pass,
               spare_used, sol_in, sol_ready,
        output cand_idx, sol_sel, solution, sol_valid, early_term, repair, done, busy
    );

    modport slave (
        output spare_struct, test_end, fault_detect, pivot_new, eval_pass,
               spare_used, sol_in, sol_ready,
        input  cand_idx, sol_sel, solution, sol_valid, early_term, repair, done, busy
    );
endinterface

// File: rtl/bira_ctrl.sv
// bira_ctrl: collects BIST pivots, sweeps spare-allocation candidates and streams the winning solution.
module bira_ctrl #(
    parameter int NUM_CAND  = 64,
    parameter int NUM_SPARE = 8,
    parameter int ANA_LAT   = 2
) (
    input logic        clk,
    input logic        rst,
    bira_ctrl_if.master bus
);
    localparam int CW = $clog2(NUM_CAND);
    localparam int SW = $clog2(NUM_SPARE);
    localparam int WW = $clog2(ANA_LAT + 2);

    typedef enum logic [2:0] {COLLECT, SETTLE, EVAL, EMIT, DONE} state_t;

    state_t        state;
    logic [3:0]    pivot_cnt;
    logic [3:0]    pivot_nxt;
    logic [3:0]    spare_total;
    logic          fault_seen;
    logic [WW-1:0] wait_cnt;
    logic [CW-1:0] cand_idx;
    logic [SW-1:0] sol_sel;
    logic          early_term;
    logic          repair;
    logic          slot_done;

    assign spare_total = bus.spare_struct == 2'd0 ? 4'd4 :
                         bus.spare_struct == 2'd1 ? 4'd6 :
                         bus.spare_struct == 2'd2 ? 4'd7 : 4'd8;
    assign pivot_nxt   = bus.pivot_new && pivot_cnt != 4'd15 ? pivot_cnt + 4'd1 : pivot_cnt;
    // an unused slot is skipped; a used one waits for the consumer
    assign slot_done   = !bus.spare_used[sol_sel] || bus.sol_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            pivot_cnt  <= '0;
            fault_seen <= 1'b0;
            wait_cnt   <= '0;
            cand_idx   <= '0;
            sol_sel    <= '0;
            early_term <= 1'b0;
            repair     <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    pivot_cnt  <= pivot_nxt;
                    fault_seen <= fault_seen | bus.fault_detect;
                    if (pivot_nxt > spare_total) begin
                        early_term <= 1'b1;
                        repair     <= 1'b0;
                        state      <= DONE;
                    end else if (bus.test_end) begin
                        if (!fault_seen && !bus.fault_detect) begin
                            repair <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cand_idx <= '0;
                            wait_cnt <= '0;
                            state    <= ANA_LAT == 0 ? EVAL : SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (int'(wait_cnt) == ANA_LAT - 1) begin
                        wait_cnt <= '0;
                        state    <= EVAL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (bus.eval_pass) begin
                        sol_sel <= '0;
                        state   <= EMIT;
                    end else if (cand_idx == CW'(NUM_CAND - 1)) begin
                        repair <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cand_idx <= cand_idx + 1'b1;
                        state    <= ANA_LAT == 0 ? EVAL : SETTLE;
                    end
                end
                EMIT: begin
                    if (slot_done) begin
                        if (sol_sel == SW'(NUM_SPARE - 1)) begin
                            repair <= 1'b1;
                            state  <= DONE;
                        end else begin
                            sol_sel <= sol_sel + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cand_idx   = cand_idx;
    assign bus.sol_sel    = sol_sel;
    assign bus.solution   = bus.sol_in;
    assign bus.sol_valid  = state == EMIT && bus.spare_used[sol_sel];
    assign bus.early_term = early_term;
    assign bus.repair     = repair;
    assign bus.done       = state == DONE;
    assign bus.busy       = state == SETTLE || state == EVAL || state == EMIT;
endmodule

// File: tb/tb_bira_ctrl.sv
// tb_bira_ctrl: directed-vector bench for bira_ctrl with a toy analyzer and solution memory.
module tb_bira_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic pass_en;
    logic [5:0] pass_idx;
    int n_cmp = 0;
    int n_err = 0;
    int words = 0;
    int vcnt = 0;
    logic [15:0] acc [64];

    bira_ctrl_if bus ();

    bira_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    // toy analyzer passes one chosen candidate; solution memory word is a function of the slot
    assign bus.eval_pass = pass_en && bus.cand_idx == pass_idx;
    assign bus.sol_in    = 16'hA000 | ({13'd0, bus.sol_sel} * 16'h0111);

    always @(posedge clk) begin
        if (rst && bus.sol_valid) vcnt <= vcnt + 1;
        if (rst && bus.sol_valid && bus.sol_ready) begin
            if (words < 64) acc[words] <= bus.solution;
            words <= words + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        bus.spare_struct = 2'd0;
        bus.test_end     = 1'b0;
        bus.fault_detect = 1'b0;
        bus.pivot_new    = 1'b0;
        bus.spare_used   = '0;
        bus.sol_ready    = 1'b0;
        pass_en          = 1'b0;
        pass_idx         = '0;
        rst              = 1'b0;
        tick;
        rst = 1'b1;
    endtask

    task automatic pulse_piv(input int n);
        bus.pivot_new = 1'b1;
        repeat (n) tick;
        bus.pivot_new = 1'b0;
    endtask

    // one fault then test_end: leaves COLLECT on the edge of the test_end cycle
    task automatic start_eval;
        bus.fault_detect = 1'b1;
        tick;
        bus.fault_detect = 1'b0;
        bus.test_end     = 1'b1;
        tick;
        bus.test_end = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!bus.done && n < max) begin
            tick;
            n++;
        end
        check("done_timeout", bus.done, 1);
    endtask

    initial begin
        int totals [4] = '{4, 6, 7, 8};
        int b;
        bus.spare_struct = 2'd0;
        bus.test_end     = 1'b0;
        bus.fault_detect = 1'b0;
        bus.pivot_new    = 1'b0;
        bus.spare_used   = '0;
        bus.sol_ready    = 1'b0;
        pass_en          = 1'b0;
        pass_idx         = '0;
        rst              = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.sol_valid, 0);
        check("rst_et", bus.early_term, 0);
        check("rst_repair", bus.repair, 0);
        check("rst_cand", bus.cand_idx, 0);
        check("rst_sel", bus.sol_sel, 0);

        // pivot overflow for every spare structure
        for (int s = 0; s < 4; s++) begin
            do_reset;
            bus.spare_struct = 2'(s);
            pulse_piv(totals[s]);
            check($sformatf("piv_at_total_%0d", s), bus.done, 0);
            pulse_piv(1);
            check($sformatf("et_%0d", s), bus.early_term, 1);
            check($sformatf("et_done_%0d", s), bus.done, 1);
            check($sformatf("et_repair_%0d", s), bus.repair, 0);
        end
        bus.test_end = 1'b1;
        bus.fault_detect = 1'b1;
        tick;
        bus.test_end = 1'b0;
        bus.fault_detect = 1'b0;
        tick;
        check("done_hold", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_et_hold", bus.early_term, 1);

        // clean test: repairable with no words
        do_reset;
        b = vcnt;
        bus.test_end = 1'b1;
        tick;
        bus.test_end = 1'b0;
        check("clean_done", bus.done, 1);
        check("clean_repair", bus.repair, 1);
        tick;
        check("clean_novalid", vcnt - b, 0);

        // candidate 3 passes, slots 0 and 2 used
        do_reset;
        bus.spare_struct = 2'd3;
        bus.spare_used   = 8'b0000_0101;
        bus.sol_ready    = 1'b1;
        pass_en          = 1'b1;
        pass_idx         = 6'd3;
        b = words;
        start_eval;
        check("sweep_busy", bus.busy, 1);
        repeat (11) tick;
        check("eval3_cand", bus.cand_idx, 3);
        check("eval3_novalid", bus.sol_valid, 0);
        tick;
        check("emit_valid", bus.sol_valid, 1);
        check("emit_sel", bus.sol_sel, 0);
        check("emit_word", bus.solution, 16'hA000);
        wait_done(30);
        check("emit_count", words - b, 2);
        check("emit_w0", acc[b], 16'hA000);
        check("emit_w1", acc[b+1], 16'hA222);
        check("emit_repair", bus.repair, 1);
        check("emit_cand_hold", bus.cand_idx, 3);
        check("emit_et", bus.early_term, 0);

        // back-pressure on slot 1
        do_reset;
        bus.spare_struct = 2'd3;
        bus.spare_used   = 8'b0000_0010;
        pass_en          = 1'b1;
        pass_idx         = 6'd0;
        b = words;
        start_eval;
        for (int i = 0; i < 10 && !bus.sol_valid; i++) tick;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), bus.sol_valid, 1);
            check($sformatf("bp_word_%0d", i), bus.solution, 16'hA111);
            tick;
        end
        check("bp_none_yet", words - b, 0);
        bus.sol_ready = 1'b1;
        tick;
        check("bp_accept", words - b, 1);
        check("bp_acc_word", acc[b], 16'hA111);
        wait_done(20);
        check("bp_repair", bus.repair, 1);

        // asynchronous abort while a word is pending
        do_reset;
        bus.spare_struct = 2'd3;
        bus.spare_used   = 8'b0000_0001;
        pass_en          = 1'b1;
        pass_idx         = 6'd1;
        start_eval;
        for (int i = 0; i < 20 && !bus.sol_valid; i++) tick;
        check("abort_pre_valid", bus.sol_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_valid", bus.sol_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_cand", bus.cand_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("abort_collect", bus.busy | bus.done, 0);
        start_eval;
        check("abort_resume", bus.busy, 1);

        // no candidate passes: failing verdict after 192 cycles
        do_reset;
        bus.spare_struct = 2'd3;
        start_eval;
        repeat (191) tick;
        check("fail_notyet", bus.done, 0);
        check("fail_cand_pre", bus.cand_idx, 63);
        tick;
        check("fail_done", bus.done, 1);
        check("fail_repair", bus.repair, 0);
        check("fail_cand", bus.cand_idx, 63);

        // overflow coincides with test_end
        do_reset;
        pulse_piv(4);
        bus.pivot_new    = 1'b1;
        bus.test_end     = 1'b1;
        bus.fault_detect = 1'b1;
        tick;
        bus.pivot_new    = 1'b0;
        bus.test_end     = 1'b0;
        bus.fault_detect = 1'b0;
        check("same_et", bus.early_term, 1);
        check("same_busy", bus.busy, 0);
        check("same_done", bus.done, 1);
        check("same_repair", bus.repair, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
